hc373_load_sequencer: RTL

- Upstream driver for the 8-bit transparent latch (74HC373 model) in the TTM4 emulator.
- Accepts byte write requests over a valid/ready handshake and presents the byte on the latch D inputs.
- Generates a latch-enable pulse with programmable setup, strobe and hold windows, and controls the latch output enable.
- Keeps a readback shadow of the last latched byte, because the latch output may be high-Z.

---
 rtl/hc373_load_sequencer_pkg.sv | 22 ++
 rtl/hc373_phase_timer.sv | 38 +++
 rtl/hc373_load_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hc373_load_sequencer_pkg.sv
// Shared definitions for the 74-series latch support blocks of the TTM4 emulator.
`default_nettype none

package hc373_load_sequencer_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // A phase of N cycles is timed by loading N-1 and ending when the counter reads zero.
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned cyc);
    return (cyc == 0) ? '0 : CNT_W'(cyc - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hc373_phase_timer.sv
// Loadable down-counter with a zero flag; times the setup, strobe and hold phases.
`default_nettype none

module hc373_phase_timer
  import hc373_load_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/hc373_load_sequencer.sv
// Drives a 74HC373 latch: accepts bytes over valid/ready, generates the LE strobe
// with programmable setup/strobe/hold windows, controls nOE and shadows the latched byte.
`default_nettype none

module hc373_load_sequencer
  import hc373_load_sequencer_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter bit          OE_BLANK   = 1'b1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       REQ_VALID,
  input  logic [7:0] REQ_DATA,
  output logic       REQ_READY,
  input  logic       OE_REQ,
  output logic [7:0] D,
  output logic       LE,
  output logic       nOE,
  output logic       DONE,
  output logic [7:0] LATCHED
);

  // A zero-length strobe would never open the latch, so it is stretched to one cycle.
  localparam int unsigned STROBE_EFF = (STROBE_CYC == 0) ? 1 : STROBE_CYC;
  localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_EFF);
  localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);

  state_t     state_q, state_d;
  logic [7:0] d_q, d_d;
  logic [7:0] latched_q, latched_d;
  logic       le_q, le_d;
  logic       noe_q, noe_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  hc373_phase_timer u_timer (
    .clk      (CLK),
    .rst_n    (nRST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    latched_d = latched_q;
    le_d      = le_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (REQ_VALID && ready_q) begin
          d_d      = REQ_DATA;
          ready_d  = 1'b0;
          tmr_load = 1'b1;
          if (SETUP_CYC > 0) begin
            state_d = SETUP;
            tmr_val = SETUP_LD;
          end else begin
            state_d = STROBE;
            le_d    = 1'b1;
            tmr_val = STROBE_LD;
          end
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_d  = STROBE;
          le_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      STROBE: begin
        if (tmr_zero) begin
          le_d      = 1'b0;
          latched_d = d_q;
          if (HOLD_CYC > 0) begin
            state_d  = HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Blanking keys off the next LE value so nOE rises in the same cycle as LE.
    noe_d = (OE_BLANK && le_d) ? 1'b1 : ~OE_REQ;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      d_q       <= 8'h00;
      latched_q <= 8'h00;
      le_q      <= 1'b0;
      noe_q     <= 1'b1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      latched_q <= latched_d;
      le_q      <= le_d;
      noe_q     <= noe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign REQ_READY = ready_q;
  assign D         = d_q;
  assign LE        = le_q;
  assign nOE       = noe_q;
  assign DONE      = done_q;
  assign LATCHED   = latched_q;

endmodule

`default_nettype wire
